// File: rtl/qsys_epcs_nios2_mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qsys_epcs_nios2_mul_pkg : shared encodings for the iterative multiply unit |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package qsys_epcs_nios2_mul_pkg;

  localparam int c_DATA_WIDTH = 32;
  localparam int c_HALF_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Weight of each partial product in issue order: aL*bL, aH*bL, aL*bH, aH*bH.
  localparam int unsigned c_PP_SHIFT [0:3] = '{0, 16, 16, 32};

endpackage : qsys_epcs_nios2_mul_pkg
`default_nettype wire

// File: rtl/qsys_epcs_nios2_mul_pp16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qsys_epcs_nios2_mul_pp16 : registered unsigned WIDTHxWIDTH multiplier cell |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module qsys_epcs_nios2_mul_pp16
  import qsys_epcs_nios2_mul_pkg::*;
#(
  parameter int    WIDTH                          = c_HALF_WIDTH,
  parameter string DEDICATED_MULTIPLIER_CIRCUITRY = "YES"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] r_p;

  if (DEDICATED_MULTIPLIER_CIRCUITRY == "YES") begin : g_dedicated
    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  end else begin : g_soft
    // Shift-and-add form keeps the product out of hard multiplier blocks.
    always_comb begin
      w_prod = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (i_b[i]) begin
          w_prod = w_prod + ({{WIDTH{1'b0}}, i_a} << i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
    end else begin
      r_p <= w_prod;
    end
  end

  assign o_p = r_p;

endmodule : qsys_epcs_nios2_mul_pp16
`default_nettype wire

// File: rtl/qsys_epcs_nios2_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qsys_epcs_nios2_mul_seq : 32x32->64 multiply built from four 16x16 passes  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module qsys_epcs_nios2_mul_seq
  import qsys_epcs_nios2_mul_pkg::*;
#(
  parameter int    DATA_WIDTH = c_DATA_WIDTH,
  parameter int    HALF_WIDTH = c_HALF_WIDTH,
  parameter string DEDICATED  = "YES"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  if (DATA_WIDTH != 32 || HALF_WIDTH * 2 != DATA_WIDTH) begin : g_param_check
    $error("qsys_epcs_nios2_mul_seq: only DATA_WIDTH=32 with HALF_WIDTH=16 is supported");
  end

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [1:0]              r_cnt;
  op_e                     r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_result;

  logic                    w_accept;
  logic                    w_acc_en;
  logic [1:0]              w_pp_sel;
  logic [HALF_WIDTH-1:0]   w_mul_a;
  logic [HALF_WIDTH-1:0]   w_mul_b;
  logic [2*HALF_WIDTH-1:0] w_pp;
  logic [2*DATA_WIDTH-1:0] w_pp_shifted;
  logic [DATA_WIDTH-1:0]   w_fix_a;
  logic [DATA_WIDTH-1:0]   w_fix_b;
  logic [DATA_WIDTH-1:0]   w_hi;
  logic [DATA_WIDTH-1:0]   w_result_sel;

  assign w_accept = start && (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_MUL;
      ST_MUL:  if (r_cnt == 2'd3) w_state_nxt = ST_ACC;
      ST_ACC:  w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit 0 of the issue counter picks the A half, bit 1 the B half.
  assign w_mul_a = r_cnt[0] ? r_a[DATA_WIDTH-1:HALF_WIDTH] : r_a[HALF_WIDTH-1:0];
  assign w_mul_b = r_cnt[1] ? r_b[DATA_WIDTH-1:HALF_WIDTH] : r_b[HALF_WIDTH-1:0];

  qsys_epcs_nios2_mul_pp16 #(
    .WIDTH                          (HALF_WIDTH),
    .DEDICATED_MULTIPLIER_CIRCUITRY (DEDICATED)
  ) u_pp16 (
    .clk (clk),
    .rst (reset),
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_pp)
  );

  // The cell output lags issue by one cycle; the counter wraps 3->0 on entry
  // to ACC, so cnt-1 names the product currently arriving in both states.
  assign w_acc_en     = ((r_state == ST_MUL) && (r_cnt != 2'd0)) || (r_state == ST_ACC);
  assign w_pp_sel     = r_cnt - 2'd1;
  assign w_pp_shifted = {{(2*DATA_WIDTH-2*HALF_WIDTH){1'b0}}, w_pp} << c_PP_SHIFT[w_pp_sel];

  // Signed high words from the unsigned product: subtract the other operand
  // for each negative signed operand.
  assign w_fix_a = (((r_op == OP_MULXSU) || (r_op == OP_MULXSS)) && r_a[DATA_WIDTH-1]) ? r_b : '0;
  assign w_fix_b = ((r_op == OP_MULXSS) && r_b[DATA_WIDTH-1]) ? r_a : '0;
  assign w_hi    = r_acc[2*DATA_WIDTH-1:DATA_WIDTH] - w_fix_a - w_fix_b;

  assign w_result_sel = (r_op == OP_MUL) ? r_acc[DATA_WIDTH-1:0] : w_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= src1;
        r_b   <= src2;
        r_op  <= op_e'(op);
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        if (r_state == ST_MUL) begin
          r_cnt <= r_cnt + 2'd1;
        end
        if (w_acc_en) begin
          r_acc <= r_acc + w_pp_shifted;
        end
      end
      r_done <= (r_state == ST_FIX);
      if (r_state == ST_FIX) begin
        r_result <= w_result_sel;
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule : qsys_epcs_nios2_mul_seq
`default_nettype wire

// File: tb/tb_qsys_epcs_nios2_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qsys_epcs_nios2_mul_seq : scoreboard bench for the multiply sequencer   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_qsys_epcs_nios2_mul_seq;

  localparam logic [1:0] c_MUL = 2'd0, c_UU = 2'd1, c_SU = 2'd2, c_SS = 2'd3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          m_free;
  logic [31:0] m_result;
  int          n_vec;
  int          n_err;

  qsys_epcs_nios2_mul_seq #(
    .DATA_WIDTH (32),
    .HALF_WIDTH (16),
    .DEDICATED  ("YES")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    sa = (o == c_MUL || o == c_UU) ? {32'd0, a} : {{32{a[31]}}, a};
    sb = (o == c_SS) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return (o == c_MUL) ? p[31:0] : p[63:32];
  endfunction

  // One cycle: check outputs of the current cycle, drive inputs, update model.
  task automatic tick(input logic st, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic rst_in);
    exp_t e;
    logic due;
    chk("busy", {63'd0, busy}, {63'd0, (cyc < m_free)});
    due = (q.size() > 0) && (q[0].cyc == cyc);
    chk("done", {63'd0, done}, {63'd0, due});
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("result", {32'd0, result}, {32'd0, e.res});
        m_result = e.res;
      end
    end else if (due) begin
      e = q.pop_front();
      m_result = e.res;
    end
    chk("result_hold", {32'd0, result}, {32'd0, m_result});

    start = st;
    op    = o;
    src1  = a;
    src2  = b;
    reset = rst_in;
    if (rst_in) begin
      q.delete();
      m_free   = cyc + 1;
      m_result = '0;
    end else if (st && cyc >= m_free) begin
      q.push_back('{model(o, a, b), cyc + 7});
      m_free = cyc + 7;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, c_MUL, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; m_free = 0; m_result = '0;
    reset = 1'b1; start = 1'b0; op = c_MUL; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed operand/opcode cases.
    tick(1'b1, c_UU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); idle(8);
    tick(1'b1, c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); idle(8);
    tick(1'b1, c_MUL, 32'h0001_2345, 32'h0001_0000, 1'b0); idle(8);
    tick(1'b1, c_SS,  32'h8000_0000, 32'h8000_0000, 1'b0); idle(8);
    tick(1'b1, c_SS,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); idle(8);
    tick(1'b1, c_SU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); idle(8);
    tick(1'b1, c_UU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); idle(8);
    tick(1'b1, c_SU,  32'h7FFF_FFFF, 32'h8000_0001, 1'b0); idle(8);

    // Start held high with alternating ops and churning operands.
    for (int i = 0; i < 22; i++) begin
      tick(1'b1, (i % 2 == 0) ? c_SS : c_MUL, $urandom, $urandom, 1'b0);
    end
    idle(8);

    // Reset mid-operation, then a fresh start two cycles later.
    tick(1'b1, c_UU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    idle(2);
    tick(1'b0, c_MUL, 32'h0, 32'h0, 1'b1);
    idle(1);
    tick(1'b1, c_SU, 32'h8765_4321, 32'hCAFE_F00D, 1'b0);
    idle(9);

    // Random traffic with random gaps.
    for (int i = 0; i < 60; i++) begin
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    end
    idle(9);
    chk("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_qsys_epcs_nios2_mul_seq
`default_nettype wire
